// File: rtl/as2650_spi_boot_loader.sv
// as2650_spi_boot_loader
//   After reset, copies BOOT_BYTES bytes from an SPI NOR flash into external
//   SRAM starting at address 0, using the multiplexed address/data bus. The
//   CPU is held in reset during the copy. When the copy completes, the loader
//   releases the CPU and the bus. If the first flash byte is 0xFF, the flash
//   is treated as blank: boot_fail is set and the CPU stays in reset.
//
// Ports
//   wb_clk_i   system clock, rising edge
//   rst        synchronous active-high reset
//   rom_cs_n   flash chip select (active low)
//   rom_sclk   flash SPI clock, mode 0
//   rom_mosi   flash data in
//   rom_miso   flash data out, sampled at the end of the sclk-high cycle
//   bus_out    multiplexed address/data to the bus
//   bus_oe     loader drives bus_out
//   le_lo      address-low latch enable
//   le_hi      address-high latch enable
//   we_n       SRAM write strobe (write on rising edge)
//   oe_n       SRAM output enable, constant 1
//   cpu_rst    hold CPU in reset
//   boot_done  copy complete (sticky until rst)
//   boot_fail  blank flash detected (sticky until rst)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RESET    | held while rst is high; all outputs at their reset values
// IDLE     | one cycle after reset release; select the flash, load command
// CMD      | shift out 0x03 + 24-bit flash address, 2 clocks per bit
// RDBYTE   | shift in one byte, 2 clocks per bit
// WR_LO    | drive addr[7:0] with le_lo
// WR_HI    | drive addr[15:8] with le_hi
// WR_DATA  | drive data with we_n low
// WR_END   | we_n high, data held; advance address
// DONE     | copy finished; CPU released (sink)
// FAIL     | blank flash; CPU held (sink)

module as2650_spi_boot_loader #(
  parameter int unsigned BOOT_BYTES = 8192,
  parameter logic [23:0] FLASH_ADDR = 24'h0
) (
  input  logic       wb_clk_i,
  input  logic       rst,
  output logic       rom_cs_n,
  output logic       rom_sclk,
  output logic       rom_mosi,
  input  logic       rom_miso,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic       le_lo,
  output logic       le_hi,
  output logic       we_n,
  output logic       oe_n,
  output logic       cpu_rst,
  output logic       boot_done,
  output logic       boot_fail
);

  typedef enum logic [3:0] {
    ST_RESET,
    ST_IDLE,
    ST_CMD,
    ST_RDBYTE,
    ST_WR_LO,
    ST_WR_HI,
    ST_WR_DATA,
    ST_WR_END,
    ST_DONE,
    ST_FAIL
  } state_t;

  // 17 bits so that a full 64 KiB image fits in the remaining-byte counter.
  localparam logic [16:0] BYTES_INIT = 17'(BOOT_BYTES);

  state_t      state;
  state_t      state_nxt;

  logic        phase;       // 0: sclk-low half of a bit, 1: sclk-high half
  logic [4:0]  bit_cnt;     // bits remaining in the current shift, down-counter
  logic [31:0] cmd_sr;
  logic [7:0]  rx_sr;
  logic [15:0] addr;
  logic [16:0] bytes_left;

  logic        bit_last;
  logic [7:0]  rx_byte;

  assign bit_last = phase && (bit_cnt == 5'd0);
  // The byte as it will be once the current miso bit is shifted in.
  assign rx_byte  = {rx_sr[6:0], rom_miso};

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (rst) begin
      state <= ST_RESET;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RESET:   state_nxt = ST_IDLE;
      ST_IDLE:    state_nxt = ST_CMD;
      ST_CMD:     if (bit_last) state_nxt = ST_RDBYTE;
      ST_RDBYTE: begin
        if (bit_last) begin
          // Only the byte destined for address 0 is checked for blank flash.
          if ((addr == 16'd0) && (rx_byte == 8'hFF)) begin
            state_nxt = ST_FAIL;
          end else begin
            state_nxt = ST_WR_LO;
          end
        end
      end
      ST_WR_LO:   state_nxt = ST_WR_HI;
      ST_WR_HI:   state_nxt = ST_WR_DATA;
      ST_WR_DATA: state_nxt = ST_WR_END;
      ST_WR_END:  state_nxt = (bytes_left == 17'd1) ? ST_DONE : ST_RDBYTE;
      ST_DONE:    state_nxt = ST_DONE;
      ST_FAIL:    state_nxt = ST_FAIL;
      default:    state_nxt = ST_RESET;
    endcase
  end

  // SPI shift and address datapath
  always_ff @(posedge wb_clk_i) begin
    if (rst) begin
      phase      <= 1'b0;
      bit_cnt    <= 5'd0;
      cmd_sr     <= 32'd0;
      rx_sr      <= 8'd0;
      addr       <= 16'd0;
      bytes_left <= 17'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          cmd_sr     <= {8'h03, FLASH_ADDR};
          bit_cnt    <= 5'd31;
          phase      <= 1'b0;
          addr       <= 16'd0;
          bytes_left <= BYTES_INIT;
        end
        ST_CMD: begin
          phase <= ~phase;
          if (phase) begin
            cmd_sr  <= {cmd_sr[30:0], 1'b0};
            // Reload for the first data byte once the command is out.
            bit_cnt <= (bit_cnt == 5'd0) ? 5'd7 : bit_cnt - 5'd1;
          end
        end
        ST_RDBYTE: begin
          phase <= ~phase;
          if (phase) begin
            rx_sr   <= rx_byte;
            bit_cnt <= (bit_cnt == 5'd0) ? 5'd7 : bit_cnt - 5'd1;
          end
        end
        ST_WR_END: begin
          // 16-bit wrap is intended: a 64 KiB copy ends with addr back at 0.
          addr       <= addr + 16'd1;
          bytes_left <= bytes_left - 17'd1;
        end
        default: ;
      endcase
    end
  end

  // Output decode
  always_comb begin
    rom_cs_n  = 1'b1;
    rom_sclk  = 1'b0;
    rom_mosi  = 1'b0;
    bus_out   = 8'h00;
    bus_oe    = 1'b0;
    le_lo     = 1'b0;
    le_hi     = 1'b0;
    we_n      = 1'b1;
    oe_n      = 1'b1;
    cpu_rst   = 1'b1;
    boot_done = 1'b0;
    boot_fail = 1'b0;
    case (state)
      ST_IDLE: begin
        rom_cs_n = 1'b0;
      end
      ST_CMD: begin
        rom_cs_n = 1'b0;
        rom_sclk = phase;
        rom_mosi = cmd_sr[31];
      end
      ST_RDBYTE: begin
        rom_cs_n = 1'b0;
        rom_sclk = phase;
      end
      // Flash stays selected with sclk parked low; the sequential read
      // continues when clocking resumes.
      ST_WR_LO: begin
        rom_cs_n = 1'b0;
        bus_oe   = 1'b1;
        bus_out  = addr[7:0];
        le_lo    = 1'b1;
      end
      ST_WR_HI: begin
        rom_cs_n = 1'b0;
        bus_oe   = 1'b1;
        bus_out  = addr[15:8];
        le_hi    = 1'b1;
      end
      ST_WR_DATA: begin
        rom_cs_n = 1'b0;
        bus_oe   = 1'b1;
        bus_out  = rx_sr;
        we_n     = 1'b0;
      end
      ST_WR_END: begin
        rom_cs_n = 1'b0;
        bus_oe   = 1'b1;
        bus_out  = rx_sr;
      end
      ST_DONE: begin
        cpu_rst   = 1'b0;
        boot_done = 1'b1;
      end
      ST_FAIL: begin
        boot_fail = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_as2650_spi_boot_loader.sv
// Testbench for as2650_spi_boot_loader: SPI flash and latched-address SRAM
// models, randomized flash images, reference expectations from the boot rules.
module tb_as2650_spi_boot_loader;

  localparam int          N    = 300;          // > 256 so addr[15:8] is exercised
  localparam logic [23:0] FA   = 24'h01_2A40;
  localparam int          BASE = 32'h2A40;     // FA[15:0]: flash model index of byte 0
  localparam logic [18:0] RST_VEC = {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0,
                                     1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  logic       wb_clk_i = 1'b0;
  logic       rst      = 1'b1;
  logic       rom_miso = 1'b0;
  logic       rom_cs_n, rom_sclk, rom_mosi;
  logic [7:0] bus_out;
  logic       bus_oe, le_lo, le_hi, we_n, oe_n, cpu_rst, boot_done, boot_fail;

  as2650_spi_boot_loader #(.BOOT_BYTES(N), .FLASH_ADDR(FA)) dut (
    .wb_clk_i (wb_clk_i),
    .rst      (rst),
    .rom_cs_n (rom_cs_n),
    .rom_sclk (rom_sclk),
    .rom_mosi (rom_mosi),
    .rom_miso (rom_miso),
    .bus_out  (bus_out),
    .bus_oe   (bus_oe),
    .le_lo    (le_lo),
    .le_hi    (le_hi),
    .we_n     (we_n),
    .oe_n     (oe_n),
    .cpu_rst  (cpu_rst),
    .boot_done(boot_done),
    .boot_fail(boot_fail)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  logic [18:0] out_vec;
  assign out_vec = {rom_cs_n, rom_sclk, rom_mosi, bus_out, bus_oe, le_lo, le_hi,
                    we_n, oe_n, cpu_rst, boot_done, boot_fail};

  logic [7:0]  flash [0:65535];
  logic [7:0]  sram  [0:65535];

  int vectors     = 0;
  int miscompares = 0;

  // Monitor state, written only by the monitor process below.
  int          cyc, end_cyc, cs_fall_cyc, cmd_cyc;
  int          fl_bits, n_rise, n_wr, n_le;
  int          n_overlap, n_oe_bad, n_drive_bad, n_mosi_bad;
  int          mon_k;
  logic [31:0] fl_cmd;
  logic        sclk_q, mosi_q;
  logic [7:0]  lat_lo, lat_hi;

  // Flash (mode 0, sequential read), external address latches and SRAM,
  // all evaluated mid-cycle on the falling clock edge.
  always @(negedge wb_clk_i) begin
    if (rst) begin
      cyc = 0; end_cyc = -1; cs_fall_cyc = -1; cmd_cyc = -1;
      fl_bits = 0; n_rise = 0; n_wr = 0; n_le = 0;
      n_overlap = 0; n_oe_bad = 0; n_drive_bad = 0; n_mosi_bad = 0;
      fl_cmd = 32'd0; sclk_q = 1'b0; mosi_q = 1'b0; rom_miso = 1'b0;
      lat_lo = 8'h00; lat_hi = 8'h00;
      // Pre-load SRAM with the complement of the image so missed writes show.
      for (int i = 0; i < N; i++) sram[16'(i)] = ~flash[16'(BASE + i)];
    end else begin
      cyc++;
      if (cs_fall_cyc < 0 && !rom_cs_n) cs_fall_cyc = cyc;
      if (end_cyc < 0 && (boot_done || boot_fail)) end_cyc = cyc;
      if (rom_cs_n) begin
        fl_bits = 0;
      end else begin
        if (rom_sclk && !sclk_q) begin
          n_rise++;
          if (fl_bits < 32) begin
            fl_cmd = {fl_cmd[30:0], rom_mosi};
            if (fl_bits == 31) cmd_cyc = cyc;
          end else if (rom_mosi !== 1'b0) begin
            n_mosi_bad++;
          end
          fl_bits++;
        end else if (!rom_sclk && sclk_q && fl_bits >= 32) begin
          mon_k = fl_bits - 32;
          rom_miso = flash[16'(fl_cmd[15:0] + 16'(mon_k / 8))][3'(7 - mon_k % 8)];
        end
        if (rom_sclk && sclk_q && rom_mosi !== mosi_q) n_mosi_bad++;
      end
      sclk_q = rom_sclk;
      mosi_q = rom_mosi;
      if (le_lo) lat_lo = bus_out;
      if (le_hi) lat_hi = bus_out;
      if (le_lo || le_hi) n_le++;
      if (!we_n) begin
        sram[{lat_hi, lat_lo}] = bus_out;
        n_wr++;
      end
      if (32'(le_lo) + 32'(le_hi) + 32'(!we_n) > 1) n_overlap++;
      if (oe_n !== 1'b1) n_oe_bad++;
      if ((le_lo || le_hi || !we_n) && !bus_oe) n_drive_bad++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge wb_clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic fill_image(input bit blank, input bit allow_ff);
    for (int i = 0; i < N + 8; i++) flash[16'(BASE + i)] = 8'($urandom);
    if (blank) flash[16'(BASE)] = 8'hFF;
    else if (!allow_ff && flash[16'(BASE)] == 8'hFF) flash[16'(BASE)] = 8'h5A;
  endtask

  // Waits for the end of a boot and compares against the expected outcome
  // derived from the image: blank first byte -> fail after the first byte,
  // otherwise N bytes copied in 1 + 64 + 20*N + 1 clocks.
  task automatic finish_run(input int run);
    bit exp_fail;
    int exp_end;
    int c;
    exp_fail = (flash[16'(BASE)] == 8'hFF);
    exp_end  = exp_fail ? (1 + 64 + 16 + 1) : (1 + 64 + 20 * N + 1);
    c = 0;
    while (!(boot_done || boot_fail) && c < exp_end + 100) begin
      tick();
      c++;
    end
    check($sformatf("r%0d_end_seen", run), 32'(boot_done | boot_fail), 32'd1);
    repeat (5) tick();
    check($sformatf("r%0d_cs_fall_cyc", run), 32'(cs_fall_cyc), 32'd1);
    check($sformatf("r%0d_cmd_cyc", run), 32'(cmd_cyc), 32'd65);
    check($sformatf("r%0d_cmd", run), fl_cmd, {8'h03, FA});
    check($sformatf("r%0d_end_cyc", run), 32'(end_cyc), 32'(exp_end));
    check($sformatf("r%0d_boot_done", run), 32'(boot_done), 32'(!exp_fail));
    check($sformatf("r%0d_boot_fail", run), 32'(boot_fail), 32'(exp_fail));
    check($sformatf("r%0d_cpu_rst", run), 32'(cpu_rst), 32'(exp_fail));
    check($sformatf("r%0d_idle_pins", run),
          32'({rom_cs_n, rom_sclk, bus_oe, le_lo, le_hi, we_n, oe_n}), 32'b1000011);
    check($sformatf("r%0d_n_wr", run), 32'(n_wr), exp_fail ? 32'd0 : 32'(N));
    check($sformatf("r%0d_n_le", run), 32'(n_le), exp_fail ? 32'd0 : 32'(2 * N));
    check($sformatf("r%0d_n_rise", run), 32'(n_rise), exp_fail ? 32'd40 : 32'(32 + 8 * N));
    check($sformatf("r%0d_overlap", run), 32'(n_overlap), 32'd0);
    check($sformatf("r%0d_oe_n", run), 32'(n_oe_bad), 32'd0);
    check($sformatf("r%0d_bus_drive", run), 32'(n_drive_bad), 32'd0);
    check($sformatf("r%0d_mosi", run), 32'(n_mosi_bad), 32'd0);
    if (!exp_fail) begin
      for (int i = 0; i < N; i++)
        check($sformatf("r%0d_sram[%0d]", run, i), 32'(sram[16'(i)]), 32'(flash[16'(BASE + i)]));
    end
  endtask

  initial begin
    int c;

    // Reset values
    fill_image(1'b0, 1'b0);
    do_reset();
    rst = 1'b1;
    tick();
    check("reset_values", 32'(out_vec), 32'(RST_VEC));
    rst = 1'b0;

    // Run 1: random image, non-blank
    fill_image(1'b0, 1'b0);
    do_reset();
    finish_run(1);

    // Run 2: blank flash
    fill_image(1'b1, 1'b0);
    do_reset();
    finish_run(2);
    check("r2_sticky_fail", 32'(boot_fail), 32'd1);

    // Run 3: reset after five bytes, then a complete copy
    fill_image(1'b0, 1'b0);
    do_reset();
    c = 0;
    while (n_wr < 5 && c < 1000) begin
      tick();
      c++;
    end
    check("r3_five_writes", 32'(n_wr), 32'd5);
    rst = 1'b1;
    tick();
    check("r3_mid_reset_values", 32'(out_vec), 32'(RST_VEC));
    repeat (2) tick();
    rst = 1'b0;
    finish_run(3);

    // Run 4: fully random image, first byte may or may not be blank
    fill_image(1'b0, 1'b1);
    do_reset();
    finish_run(4);
    repeat (20) tick();
    check("r4_sticky_end", 32'({boot_done, boot_fail}),
          (flash[16'(BASE)] == 8'hFF) ? 32'b01 : 32'b10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
